// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  // Operation encodings. Bit 1 selects divide, bit 0 selects signed.
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // Control FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;

  // One result bit is produced per CALC cycle.
  localparam int ITERATIONS = 32;

  // True for either divide encoding.
  function automatic logic is_div(input logic [1:0] op_code);
    return op_code[1];
  endfunction

  // True for either signed encoding.
  function automatic logic is_signed(input logic [1:0] op_code);
    return op_code[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand
// magnitudes on entry and to restore result signs on exit.
module sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  // Pass through or negate.
  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result
// registers. Operands are reduced to magnitudes on launch, processed
// for 32 cycles by a shared shift datapath, then sign-corrected.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clock_in,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] writeData,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [1:0]  state;
  logic [5:0]  count;

  // Launch-time copies; later operand changes are invisible.
  logic        div_q;
  logic        sign_a;
  logic        sign_b;
  logic        div_zero;

  // acc: product (multiply) or {remainder, quotient} (divide).
  // mcand: multiplicand or divisor magnitude.
  logic [63:0] acc;
  logic [31:0] mcand;
  logic [63:0] acc_next;

  logic        in_sign_a;
  logic        in_sign_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  logic        neg_result;
  logic [63:0] prod_fixed;
  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Unsigned operations never treat bit 31 as a sign.
  assign in_sign_a = is_signed(op) & operandA[31];
  assign in_sign_b = is_signed(op) & operandB[31];

  sign_fix #(.WIDTH(32)) u_abs_a (.value(operandA), .negate(in_sign_a), .result(abs_a));
  sign_fix #(.WIDTH(32)) u_abs_b (.value(operandB), .negate(in_sign_b), .result(abs_b));

  // Product and quotient are negative when operand signs differ;
  // remainder follows the dividend sign.
  assign neg_result = sign_a ^ sign_b;

  sign_fix #(.WIDTH(64)) u_fix_prod (.value(acc),         .negate(neg_result), .result(prod_fixed));
  sign_fix #(.WIDTH(32)) u_fix_quot (.value(acc[31:0]),  .negate(neg_result), .result(quot_fixed));
  sign_fix #(.WIDTH(32)) u_fix_rem  (.value(acc[63:32]), .negate(sign_a),     .result(rem_fixed));

  assign busy = (state != ST_IDLE);

  // One shift-add (multiply) or restoring shift-subtract (divide) step.
  always_comb begin
    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic [31:0] diff;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    acc_next  = acc;
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, mcand};
    rem_shift = acc[63:31];
    diff      = rem_shift[31:0] - mcand;
    if (div_q) begin
      if (rem_shift >= {1'b0, mcand}) begin
        acc_next = {diff, acc[30:0], 1'b1};
      end else begin
        acc_next = {rem_shift[31:0], acc[30:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_next = {mul_sum, acc[31:1]};
      end else begin
        acc_next = {1'b0, acc[63:32], acc[31:1]};
      end
    end
  end

  // Sign-corrected results; divide-by-zero forces an all-ones quotient
  // while the corrected remainder reproduces the original dividend.
  always_comb begin
    res_hi = prod_fixed[63:32];
    res_lo = prod_fixed[31:0];
    if (div_q) begin
      res_hi = rem_fixed;
      res_lo = div_zero ? 32'hFFFF_FFFF : quot_fixed;
    end
  end

  // Control FSM, iteration counter, done pulse and HI/LO registers.
  always_ff @(posedge clock_in) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples the pre-edge value of the others.
    if (reset) begin
      state <= ST_IDLE;
      count <= 6'd0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CALC;
            count <= 6'd0;
          end else begin
            if (mthi) hi <= writeData;
            if (mtlo) lo <= writeData;
          end
        end
        ST_CALC: begin
          count <= count + 6'd1;
          if (count == 6'(ITERATIONS - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          count <= 6'd0;
          done  <= 1'b1;
          hi    <= res_hi;
          lo    <= res_lo;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers: loaded on launch, stepped during CALC.
  always_ff @(posedge clock_in) begin
    // NOTE: no reset here; these are always loaded at launch before any
    // use, and the control FSM alone decides whether results are kept.
    if (state == ST_IDLE && start) begin
      div_q    <= is_div(op);
      sign_a   <= in_sign_a;
      sign_b   <= in_sign_b;
      div_zero <= is_div(op) && (operandB == 32'd0);
      acc      <= {32'd0, abs_a};
      mcand    <= abs_b;
    end else if (state == ST_CALC) begin
      acc <= acc_next;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        mthi;
  logic        mtlo;
  logic [31:0] writeData;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec  = 0;
  int n_miss = 0;

  mul_div_unit dut (
    .clock_in (clock_in),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .operandA (operandA),
    .operandB (operandB),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .writeData(writeData),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one launch at a negedge, hold across the edge, then scramble
  // operands and op so any late sampling shows up in the result.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic mh, input logic ml, input logic [31:0] wd);
    @(negedge clock_in);
    start = 1'b1; op = o; operandA = a; operandB = b;
    mthi = mh; mtlo = ml; writeData = wd;
    @(posedge clock_in);
    #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    operandA = ~a; operandB = b + 32'd1; op = ~o;
  endtask

  // Sample at negedges until done, bounded; cnt is the sample index
  // counted from the launch edge.
  task automatic wait_done(input int cnt0, output int cnt, output int bcnt, output logic seen);
    cnt  = cnt0;
    bcnt = cnt0;
    seen = 1'b0;
    while (!seen && cnt < 60) begin
      @(negedge clock_in);
      cnt++;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int   cnt;
    int   bcnt;
    logic seen;
    launch(o, a, b, 1'b0, 1'b0, 32'd0);
    wait_done(0, cnt, bcnt, seen);
    check({tag, " done seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(cnt), 64'd34);
    check({tag, " busy cycles"}, 64'(bcnt), 64'd33);
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clock_in);
    check({tag, " done one cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int   cnt;
    int   bcnt;
    int   done_cnt;
    logic seen;

    reset = 1'b1; start = 1'b0; op = 2'b00; operandA = 32'd0; operandB = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; writeData = 32'd0;
    repeat (2) @(posedge clock_in);
    #1 reset = 1'b0;
    @(negedge clock_in);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);

    // Direct moves in IDLE.
    @(negedge clock_in); mthi = 1'b1; writeData = 32'h1234_5678;
    @(posedge clock_in); #1 mthi = 1'b0;
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi lo untouched", 64'(lo), 64'd0);
    @(negedge clock_in); mthi = 1'b1; mtlo = 1'b1; writeData = 32'hAAAA_5555;
    @(posedge clock_in); #1 mthi = 1'b0; mtlo = 1'b0;
    check("mthi+mtlo hi", 64'(hi), 64'hAAAA_5555);
    check("mthi+mtlo lo", 64'(lo), 64'hAAAA_5555);
    @(negedge clock_in); mtlo = 1'b1; writeData = 32'hCAFE_F00D;
    @(posedge clock_in); #1 mtlo = 1'b0;
    check("mtlo lo", 64'(lo), 64'hCAFE_F00D);
    check("mtlo hi untouched", 64'(hi), 64'hAAAA_5555);

    // Start together with mthi: start wins, move dropped.
    launch(OP_MULTU, 32'd2, 32'd3, 1'b1, 1'b0, 32'h1234_5678);
    check("start+mthi hi kept", 64'(hi), 64'hAAAA_5555);
    check("start+mthi busy", 64'(busy), 64'd1);
    wait_done(0, cnt, bcnt, seen);
    check("2x3 done seen", 64'(seen), 64'd1);
    check("2x3 hi", 64'(hi), 64'd0);
    check("2x3 lo", 64'(lo), 64'd6);

    run_op("multu max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult extr",   OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
    run_op("div -7/2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/0",    OP_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div -7/0",    OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu 100/7",  OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);
    run_op("div 7/-2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

    // Second start plus mthi while busy: both ignored, no queuing.
    launch(OP_MULTU, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0);
    repeat (9) @(negedge clock_in);
    @(negedge clock_in);
    start = 1'b1; op = OP_DIVU; operandA = 32'd9; operandB = 32'd3;
    mthi = 1'b1; writeData = 32'hDEAD_BEEF;
    @(posedge clock_in); #1 start = 1'b0; mthi = 1'b0;
    check("busy mthi ignored", 64'(hi), 64'h0000_0001);
    wait_done(10, cnt, bcnt, seen);
    check("5x5 done seen", 64'(seen), 64'd1);
    check("5x5 latency", 64'(cnt), 64'd34);
    check("5x5 hi", 64'(hi), 64'd0);
    check("5x5 lo", 64'(lo), 64'd25);
    @(negedge clock_in);
    check("no queued op", 64'(busy), 64'd0);

    // Reset mid-operation, with start and mthi also asserted.
    launch(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
    repeat (9) @(negedge clock_in);
    @(negedge clock_in);
    reset = 1'b1; start = 1'b1; op = OP_MULTU; operandA = 32'd2; operandB = 32'd2;
    mthi = 1'b1; writeData = 32'h0000_FFFF;
    @(posedge clock_in); #1 reset = 1'b0; start = 1'b0; mthi = 1'b0;
    @(negedge clock_in);
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock_in);
      if (done) done_cnt++;
    end
    check("abort no done", 64'(done_cnt), 64'd0);
    check("abort lo held", 64'(lo), 64'd0);

    run_op("post-abort", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have these ports: clock_in  input  1  single clock, all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  launch request for an operation; sampled only in IDLE.
REQ-004 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 operandA  input  32  rs value, sourced from register-file readData1.
REQ-006 operandB  input  32  rt value, sourced from register-file readData2.
REQ-007 mthi / mtlo  input  1 each  load HI / LO directly from writeData.
REQ-008 writeData  input  32  data for mthi/mtlo.
REQ-009 busy  output  1  operation in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 hi, lo  output  32 each  registered HI/LO results, feeding MFHI/MFLO writeback to the register file.

Function
REQ-012 The block SHALL implement states IDLE, CALC and FIX, with transitions IDLE->CALC on start, CALC->FIX after the 32nd iteration, and FIX->IDLE unconditionally.
REQ-013 When start is sampled high in IDLE at edge E0, the block SHALL latch op, |operandA|, |operandB| and both sign bits, and SHALL ignore later operand changes.
REQ-014 The block SHALL perform one iteration per edge at E1..E32: shift-add for multiply, restoring shift-subtract for divide, with a 6-bit iteration counter.
REQ-015 At E33 (FIX), the block SHALL apply sign correction and write hi/lo; done SHALL be 1 for exactly the cycle after E33.
REQ-016 busy SHALL be 1 from after E0 through E33 inclusive, and 0 while done=1.
REQ-017 Multiply SHALL produce {hi,lo} = full 64-bit product; MULT SHALL negate the product when signA^signB.
REQ-018 Divide SHALL produce lo = quotient and hi = remainder; for DIV, the quotient sign is signA^signB and the remainder takes the sign of operandA.
REQ-019 For divide-by-zero, the block SHALL set hi = operandA and lo = 32'hFFFFFFFF, with normal 33-edge timing and done pulse.
REQ-020 For DIV 32'h80000000 / 32'hFFFFFFFF, the block SHALL set lo = 32'h80000000 and hi = 0.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 mthi/mtlo in IDLE SHALL load hi/lo from writeData at the next edge; both asserted SHALL load both.
REQ-023 mthi/mtlo while busy=1 SHALL be ignored.
REQ-024 start together with mthi/mtlo in IDLE: start SHALL win and the moves SHALL be dropped.
REQ-025 hi/lo SHALL hold their value except on FIX completion, mthi/mtlo, or reset.

Reset
REQ-026 reset high at a rising edge SHALL force state IDLE, busy=0, done=0, hi=0, lo=0, and counter=0.
REQ-027 reset during CALC or FIX SHALL abort the operation with no done pulse and no hi/lo update.
REQ-028 reset SHALL have priority over start, mthi and mtlo.

Structure
REQ-029 A shared package SHALL hold the op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), state encodings, and ITERATIONS=32.
REQ-030 One sub-module, sign_fix, SHALL be provided: a combinational conditional two's-complement negate used for operand abs and result correction.
REQ-031 The datapath SHALL use a single 64-bit accumulator/remainder register and a 32-bit multiplicand/divisor register shared by multiply and divide.

Verification
REQ-032 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> 33 edges later done=1, hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-033 MULT -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high for exactly 33 cycles.
REQ-034 DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 7 / 0 -> hi=32'h00000007, lo=32'hFFFFFFFF.
REQ-035 Start MULTU 5x5, then a second start (DIVU 9/3) plus mthi=1 at cycle 10 -> both ignored; final hi=0, lo=25.
REQ-036 Start DIVU 100/7, reset at cycle 10 -> next cycle busy=0, hi=lo=0, and no done pulse within 40 cycles.
REQ-037 IDLE mthi with writeData=32'h12345678 plus same-cycle start MULTU 2x3 -> mthi dropped; result hi=0, lo=6.
